// File: rtl/demux_sched_pkg.sv
// Shared encodings for the demux lane scheduler: steering modes, FSM states
// and the mode-dependent input-ready rule.
package demux_sched_pkg;

    // Steering modes
    localparam logic [1:0] MODE_RR = 2'd0;   // round-robin between lanes
    localparam logic [1:0] MODE_L0 = 2'd1;   // force lane 0
    localparam logic [1:0] MODE_L1 = 2'd2;   // force lane 1
    localparam logic [1:0] MODE_BC = 2'd3;   // broadcast to both lanes

    // Scheduler FSM states
    localparam logic [1:0] STATE_IDLE   = 2'd0;
    localparam logic [1:0] STATE_ACTIVE = 2'd1;
    localparam logic [1:0] STATE_STALL  = 2'd2;

    // Input side may accept when the lane(s) the mode would target can take a word.
    function automatic logic mode_ready(input logic [1:0] mode, input logic [1:0] free);
        logic rdy;
        case (mode)
            MODE_RR: rdy = free[0] | free[1];
            MODE_L0: rdy = free[0];
            MODE_L1: rdy = free[1];
            default: rdy = free[0] & free[1];
        endcase
        return rdy;
    endfunction

endpackage

// File: rtl/demux_lane_reg.sv
// One registered output lane: holds a word until the consumer takes it,
// can drain and reload in the same cycle, and counts delivered words.
module demux_lane_reg #(
    parameter int DATA_W = 4,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_load_data,
    input  logic              i_ready_out,
    output logic [DATA_W-1:0] o_data_out,
    output logic              o_valid_out,
    output logic              o_free,
    output logic [CNT_W-1:0]  o_cnt
);

    logic [DATA_W-1:0] r_data;
    logic              r_valid;
    logic [CNT_W-1:0]  r_cnt;
    logic              w_xfer;

    // A lane that is empty, or whose word leaves this cycle, can take a new one.
    assign o_free = ~r_valid | i_ready_out;
    assign w_xfer = r_valid & i_ready_out;

    // Output slice: load wins over drain so a same-cycle reload keeps valid high.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_data  <= i_load_data;
            r_valid <= 1'b1;
        end else if (w_xfer) begin
            r_valid <= 1'b0;
        end
    end

    // Delivered-word counter, wraps naturally at 2^CNT_W.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_xfer) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_data_out  = r_data;
    assign o_valid_out = r_valid;
    assign o_cnt       = r_cnt;

endmodule

// File: rtl/demux_lane_scheduler.sv
// 1:2 demultiplexer controller: accepts a valid/ready word stream and steers
// each word to lane 0, lane 1 or both according to the steering mode.
module demux_lane_scheduler #(
    parameter int DATA_W = 4,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid_in,
    output logic              ready_in,
    input  logic [1:0]        mode,
    output logic [DATA_W-1:0] data_out0,
    output logic              valid_out0,
    input  logic              ready_out0,
    output logic [DATA_W-1:0] data_out1,
    output logic              valid_out1,
    input  logic              ready_out1,
    output logic [CNT_W-1:0]  cnt0,
    output logic [CNT_W-1:0]  cnt1,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic              busy
);

    import demux_sched_pkg::*;

    logic [1:0]        w_free;
    logic [1:0]        w_valid;
    logic [1:0]        w_load;
    logic [1:0]        w_ready_out;
    logic [1:0]        w_valid_next;
    logic [DATA_W-1:0] w_data_out [2];
    logic [CNT_W-1:0]  w_cnt [2];
    logic              w_accept;
    logic              w_stall;
    logic              w_rr_lane;
    logic [1:0]        w_state_next;

    logic              r_ptr;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic [1:0]        r_state;

    assign w_ready_out = {ready_out1, ready_out0};

    // Never advertise readiness while reset is asserted.
    assign ready_in = ~reset & mode_ready(mode, w_free);
    assign w_accept = valid_in & ready_in;
    assign w_stall  = valid_in & ~ready_in;

    // Round-robin target: the pointed lane if free, otherwise the other one
    // (the pointer is left alone so the skipped lane keeps priority).
    assign w_rr_lane = w_free[r_ptr] ? r_ptr : ~r_ptr;

    // Per-lane load strobes for the accepted word.
    always_comb begin
        w_load = 2'b00;
        if (w_accept) begin
            case (mode)
                MODE_RR: w_load = {w_rr_lane, ~w_rr_lane};
                MODE_L0: w_load = 2'b01;
                MODE_L1: w_load = 2'b10;
                default: w_load = 2'b11;
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lane
            demux_lane_reg #(
                .DATA_W (DATA_W),
                .CNT_W  (CNT_W)
            ) u_lane (
                .clk         (clk),
                .reset       (reset),
                .i_load      (w_load[gi]),
                .i_load_data (data_in),
                .i_ready_out (w_ready_out[gi]),
                .o_data_out  (w_data_out[gi]),
                .o_valid_out (w_valid[gi]),
                .o_free      (w_free[gi]),
                .o_cnt       (w_cnt[gi])
            );

            // Lane valid as it will be after this edge, used by the FSM.
            assign w_valid_next[gi] = w_load[gi] | (w_valid[gi] & ~w_ready_out[gi]);
        end
    endgenerate

    // Round-robin pointer toggles only when the pointed lane took the word.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= 1'b0;
        end else if (w_accept && (mode == MODE_RR) && w_free[r_ptr]) begin
            r_ptr <= ~r_ptr;
        end
    end

    // Count cycles where the producer offers a word that cannot be taken.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (w_stall) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    // FSM next state with precedence STALL > ACTIVE > IDLE. A stall implies a
    // blocked lane that stays valid, so state != IDLE tracks any lane valid.
    always_comb begin
        if (w_stall) begin
            w_state_next = STATE_STALL;
        end else if (|w_valid_next) begin
            w_state_next = STATE_ACTIVE;
        end else begin
            w_state_next = STATE_IDLE;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= STATE_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    assign busy       = (r_state != STATE_IDLE);
    assign data_out0  = w_data_out[0];
    assign data_out1  = w_data_out[1];
    assign valid_out0 = w_valid[0];
    assign valid_out1 = w_valid[1];
    assign cnt0       = w_cnt[0];
    assign cnt1       = w_cnt[1];
    assign stall_cnt  = r_stall_cnt;

endmodule
